wb_rr_arb: RTL and testbench
============================

Name: wb_rr_arb

Overview:
- Synthesizable 4-master to 1-slave Wishbone arbiter/multiplexer for the conmax fabric.
- Grants the shared slave port round-robin and holds the grant for the whole CYC assertion, so bursts and read-modify-write sequences with STB gaps stay atomic.
- Routes ACK/ERR/RTY back to the owner only.
- A watchdog terminates stalled strobes with ERR.

Parameters:
- NUM_M, 4, number of masters (2..8)
- AW, 32, address width
- DW, 32, data width
- SW, 4, byte-select width (DW/8)
- TO_CYC, 255, cycles an unanswered strobe may wait before forced ERR (1..255; 8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m_adr_i  in  NUM_M*AW  master addresses, master k in slice k
- m_dat_i  in  NUM_M*DW  master write data
- m_sel_i  in  NUM_M*SW  master byte selects
- m_we_i  in  NUM_M  master write enables
- m_cyc_i  in  NUM_M  master cycle requests
- m_stb_i  in  NUM_M  master strobes
- m_dat_o  out  DW  slave read data, broadcast to all masters
- m_ack_o  out  NUM_M  per-master ack
- m_err_o  out  NUM_M  per-master err
- m_rty_o  out  NUM_M  per-master retry
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_sel_o  out  SW  slave byte select
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave err
- s_rty_i  in  1  slave retry
- gnt_o  out  clog2(NUM_M)  current owner index
- gnt_vld_o  out  1  grant held
- to_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clock and reset: one clock clk. Reset rst is asynchronous, active-high.
- Reset values:
  - gnt=0, gnt_vld=0, last=NUM_M-1, wd_cnt=0, to_o=0.
  - All s_* outputs are 0.
  - m_ack/err/rty are 0.
  - Reset mid-transfer drops s_cyc_o/s_stb_o immediately (combinational from the cleared grant).
- FSM states:
  - IDLE (gnt_vld=0): if any m_cyc_i is high, search from last+1 upward with wrap-around; the first requester becomes gnt. At the next edge, gnt_vld=1 and the FSM enters OWN. Arbitration latency is 1 cycle from CYC to s_cyc_o.
  - OWN: hold gnt while m_cyc_i[gnt]=1, regardless of other requests or STB gaps. When m_cyc_i[gnt]=0, set gnt_vld=0, last=gnt, return to IDLE. A new grant is therefore issued at the earliest one cycle after release, giving one idle slave cycle between owners.
- Muxing (combinational, valid only in OWN; otherwise all s_* = 0):
  - s_adr/dat/sel/we = slice gnt.
  - s_cyc_o = m_cyc_i[gnt].
  - s_stb_o = m_stb_i[gnt] & m_cyc_i[gnt] & ~to_o.
- Response routing:
  - m_ack_o[gnt] = s_ack_i & s_stb_o.
  - m_err_o[gnt] = (s_err_i & s_stb_o) | to_o.
  - m_rty_o[gnt] = s_rty_i & s_stb_o.
  - Non-owners always see 0.
  - m_dat_o = s_dat_i unconditionally.
- Watchdog:
  - wd_cnt increments each cycle that s_stb_o=1 and ack|err|rty=0.
  - wd_cnt clears on any response, on s_stb_o=0, or on leaving OWN.
  - When wd_cnt==TO_CYC-1 and still no response, to_o=1 for the next cycle. During that cycle s_stb_o is forced to 0, the owner sees ERR, and wd_cnt clears.
  - A slave response arriving in the same cycle as expiry wins: no to_o.
- Simultaneous events:
  - Owner drops CYC in the same cycle the slave acks: the ack is still routed (ack already qualified by stb), and the grant is released at that edge.
  - All masters requesting: strict rotation 0→1→2→3→0.

Decomposition:
- Package wb_arb_pkg: AW/DW/SW defaults, TO_CYC default, the state encoding (IDLE/OWN), and a function for the wrap-around round-robin priority pick.
- One sub-module, wb_rr_pick: combinational next-owner search given req vector and last.
- The mux, FSM and watchdog stay in wb_rr_arb.

Test Plan:
- Single read: master 2 raises CYC/STB with adr=0x0000_0010; slave acks with dat 0xDEAD_BEEF 2 cycles after s_stb_o. Required: s_cyc_o rises 1 cycle after m_cyc_i; only m_ack_o[2] pulses; m_dat_o=0xDEAD_BEEF; gnt_o=2.
- Fairness: all 4 masters hold CYC continuously, each doing one write then dropping CYC and re-requesting. Required: grant order 0,1,2,3,0 with exactly one idle cycle between owners.
- Burst hold: master 1 does a 4-word write at 0x100/104/108/10C with 3-cycle STB gaps while master 0 requests. Required: gnt_o stays 1 across all four acks; master 0 granted only after m_cyc_i[1] falls.
- Watchdog (TO_CYC=8): slave never responds to master 3. Required: to_o and m_err_o[3] pulse in the 9th cycle after s_stb_o rose; s_stb_o=0 that cycle; grant is kept until CYC drops.
- Error/retry routing: slave returns ERR to master 0, then RTY to master 1. Required: each response appears only on the owner's m_err_o/m_rty_o; other bits stay 0.
- Reset mid-transfer: assert rst while master 2 owns with STB high. Required: s_cyc_o/s_stb_o drop asynchronously and gnt_vld_o=0; after release, master 0 is granted first (last=3).

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared defaults, FSM encoding and round-robin pick helper
// for the 4:1 Wishbone arbiter (wb_rr_arb) and its pick sub-block.
package wb_arb_pkg;

   localparam int AW_D     = 32;
   localparam int DW_D     = 32;
   localparam int SW_D     = 4;
   localparam int TO_CYC_D = 255;
   localparam int MAX_M    = 8;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_st_e;

   // Returns {found, index}. Search starts at last+1 and wraps mod n, so
   // the previous owner is considered last.
   function automatic logic [3:0] rr_pick(
      input logic [MAX_M-1:0] req,
      input logic [2:0]       last,
      input int unsigned      n
   );
      logic [3:0]  r;
      int unsigned idx;
      r   = '0;
      idx = 0;
      for (int unsigned k = 1; k <= MAX_M; k++) begin
         idx = (32'(last) + k) % n;
         if (!r[3] && k <= n && req[idx[2:0]]) begin
            r = {1'b1, idx[2:0]};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational next-owner search over the CYC request vector.
// Ports: req_i (requests), last_i (previous owner), gnt_o (winner), any_o.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NUM_M = 4,
   parameter int GW    = 2
) (
   input  logic [NUM_M-1:0] req_i,
   input  logic [GW-1:0]    last_i,
   output logic [GW-1:0]    gnt_o,
   output logic             any_o
);

   logic [MAX_M-1:0] req8;
   logic [3:0]       res;

   always_comb begin
      req8              = '0;
      req8[NUM_M-1:0]   = req_i;
      res               = rr_pick(req8, 3'(last_i), NUM_M);
      gnt_o             = GW'(res[2:0]);
      any_o             = res[3];
   end

endmodule

// File: rtl/wb_rr_arb.sv
// wb_rr_arb: NUM_M-master to 1-slave Wishbone arbiter/mux, round-robin,
// grant held for the whole CYC, per-owner response routing, STB watchdog.
// Ports: clk/rst; m_* master side (sliced per master); s_* slave side;
// gnt_o/gnt_vld_o current owner; to_o one-cycle watchdog expiry pulse.
module wb_rr_arb
   import wb_arb_pkg::*;
#(
   parameter int NUM_M  = 4,
   parameter int AW     = AW_D,
   parameter int DW     = DW_D,
   parameter int SW     = SW_D,
   parameter int TO_CYC = TO_CYC_D
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_M*AW-1:0]      m_adr_i,
   input  logic [NUM_M*DW-1:0]      m_dat_i,
   input  logic [NUM_M*SW-1:0]      m_sel_i,
   input  logic [NUM_M-1:0]         m_we_i,
   input  logic [NUM_M-1:0]         m_cyc_i,
   input  logic [NUM_M-1:0]         m_stb_i,
   output logic [DW-1:0]            m_dat_o,
   output logic [NUM_M-1:0]         m_ack_o,
   output logic [NUM_M-1:0]         m_err_o,
   output logic [NUM_M-1:0]         m_rty_o,
   output logic [AW-1:0]            s_adr_o,
   output logic [DW-1:0]            s_dat_o,
   output logic [SW-1:0]            s_sel_o,
   output logic                     s_we_o,
   output logic                     s_cyc_o,
   output logic                     s_stb_o,
   input  logic [DW-1:0]            s_dat_i,
   input  logic                     s_ack_i,
   input  logic                     s_err_i,
   input  logic                     s_rty_i,
   output logic [$clog2(NUM_M)-1:0] gnt_o,
   output logic                     gnt_vld_o,
   output logic                     to_o
);

   localparam int GW = $clog2(NUM_M);

   arb_st_e     st_q;
   logic [GW-1:0] gnt_q;
   logic [GW-1:0] last_q;
   logic [7:0]  wd_q;
   logic        to_q;

   logic [GW-1:0] pick_gnt;
   logic        pick_any;
   logic        own;
   logic        cyc_g;
   logic        stb_g;
   logic        stb_s;
   logic        resp;
   int unsigned gi;

   wb_rr_pick #(
      .NUM_M (NUM_M),
      .GW    (GW)
   ) u_pick (
      .req_i  (m_cyc_i),
      .last_i (last_q),
      .gnt_o  (pick_gnt),
      .any_o  (pick_any)
   );

   assign own   = (st_q == OWN);
   assign gi    = 32'(gnt_q);
   assign cyc_g = m_cyc_i[gnt_q];
   assign stb_g = m_stb_i[gnt_q];
   // Expiry cycle blanks the strobe so the slave sees the access abandoned.
   assign stb_s = own & cyc_g & stb_g & ~to_q;
   assign resp  = s_ack_i | s_err_i | s_rty_i;

   assign gnt_o     = gnt_q;
   assign gnt_vld_o = own;
   assign to_o      = to_q;
   assign s_stb_o   = stb_s;
   assign s_cyc_o   = own & cyc_g;
   assign m_dat_o   = s_dat_i;

   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      if (own) begin
         s_adr_o = m_adr_i[gi*AW +: AW];
         s_dat_o = m_dat_i[gi*DW +: DW];
         s_sel_o = m_sel_i[gi*SW +: SW];
         s_we_o  = m_we_i[gnt_q];
      end
   end

   always_comb begin
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
      if (own) begin
         m_ack_o[gnt_q] = s_ack_i & stb_s;
         m_err_o[gnt_q] = (s_err_i & stb_s) | to_q;
         m_rty_o[gnt_q] = s_rty_i & stb_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= IDLE;
         gnt_q  <= '0;
         last_q <= GW'(NUM_M - 1);
         wd_q   <= '0;
         to_q   <= 1'b0;
      end else begin
         unique case (st_q)
            IDLE: begin
               wd_q <= '0;
               to_q <= 1'b0;
               if (pick_any) begin
                  gnt_q <= pick_gnt;
                  st_q  <= OWN;
               end
            end
            OWN: begin
               if (!cyc_g) begin
                  st_q   <= IDLE;
                  last_q <= gnt_q;
                  wd_q   <= '0;
                  to_q   <= 1'b0;
               end else if (to_q) begin
                  wd_q <= '0;
                  to_q <= 1'b0;
               end else if (stb_s && !resp) begin
                  // A response in the expiry cycle suppresses the timeout.
                  if (wd_q == 8'(TO_CYC - 1)) begin
                     wd_q <= '0;
                     to_q <= 1'b1;
                  end else begin
                     wd_q <= wd_q + 8'd1;
                  end
               end else begin
                  wd_q <= '0;
               end
            end
            default: begin
               st_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arb.sv
// tb_wb_rr_arb: scoreboard bench for wb_rr_arb (NUM_M=4, TO_CYC=8).
// Expected grants/responses are queued by stimulus, popped by a monitor.
module tb_wb_rr_arb;

   localparam int NM = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [AW-1:0] adr[NM];
   logic [DW-1:0] wdat[NM];
   logic [SW-1:0] sel[NM];
   logic          we[NM];
   logic          cyc[NM];
   logic          stb[NM];

   logic [NM*AW-1:0] m_adr_i;
   logic [NM*DW-1:0] m_dat_i;
   logic [NM*SW-1:0] m_sel_i;
   logic [NM-1:0]    m_we_i;
   logic [NM-1:0]    m_cyc_i;
   logic [NM-1:0]    m_stb_i;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o;
   logic [NM-1:0]    m_err_o;
   logic [NM-1:0]    m_rty_o;
   logic [AW-1:0]    s_adr_o;
   logic [DW-1:0]    s_dat_o;
   logic [SW-1:0]    s_sel_o;
   logic             s_we_o;
   logic             s_cyc_o;
   logic             s_stb_o;
   logic [DW-1:0]    s_dat_i = '0;
   logic             s_ack_i = 1'b0;
   logic             s_err_i = 1'b0;
   logic             s_rty_i = 1'b0;
   logic [1:0]       gnt_o;
   logic             gnt_vld_o;
   logic             to_o;

   always_comb begin
      m_adr_i = '0;
      m_dat_i = '0;
      m_sel_i = '0;
      m_we_i  = '0;
      m_cyc_i = '0;
      m_stb_i = '0;
      for (int k = 0; k < NM; k++) begin
         m_adr_i[k*AW +: AW] = adr[k];
         m_dat_i[k*DW +: DW] = wdat[k];
         m_sel_i[k*SW +: SW] = sel[k];
         m_we_i[k]           = we[k];
         m_cyc_i[k]          = cyc[k];
         m_stb_i[k]          = stb[k];
      end
   end

   wb_rr_arb #(
      .NUM_M  (NM),
      .AW     (AW),
      .DW     (DW),
      .SW     (SW),
      .TO_CYC (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_adr_i   (m_adr_i),
      .m_dat_i   (m_dat_i),
      .m_sel_i   (m_sel_i),
      .m_we_i    (m_we_i),
      .m_cyc_i   (m_cyc_i),
      .m_stb_i   (m_stb_i),
      .m_dat_o   (m_dat_o),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_rty_o   (m_rty_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_sel_o   (s_sel_o),
      .s_we_o    (s_we_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_dat_i   (s_dat_i),
      .s_ack_i   (s_ack_i),
      .s_err_i   (s_err_i),
      .s_rty_i   (s_rty_i),
      .gnt_o     (gnt_o),
      .gnt_vld_o (gnt_vld_o),
      .to_o      (to_o)
   );

   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int gnt;
      int idle;
   } gexp_t;

   typedef struct {
      logic [3:0]  ack;
      logic [3:0]  err;
      logic [3:0]  rty;
      logic        to;
      logic        stb;
      int          gnt;
      int          cyc;
      logic [31:0] dat;
      logic [31:0] adr;
      int          ck;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   function automatic void pg(input int g, input int idle);
      gexp_t e;
      e.gnt  = g;
      e.idle = idle;
      gq.push_back(e);
   endfunction

   function automatic void pr(input int kind, input int m, input int c,
                              input int ck, input logic [31:0] d,
                              input logic [31:0] a, input logic t,
                              input logic s);
      rexp_t      e;
      logic [3:0] b;
      b     = 4'b0001 << m;
      e.ack = (kind == 0) ? b : 4'b0;
      e.err = (kind == 1) ? b : 4'b0;
      e.rty = (kind == 2) ? b : 4'b0;
      e.to  = t;
      e.stb = s;
      e.gnt = m;
      e.cyc = c;
      e.dat = d;
      e.adr = a;
      e.ck  = ck;
      rq.push_back(e);
   endfunction

   // Slave model: sl_mode 0 ack, 1 err, 2 rty, 3 silent.
   int          sl_mode = 0;
   int          sl_lat  = 0;
   logic [31:0] sl_dat  = '0;
   int          sl_cnt  = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (s_ack_i | s_err_i | s_rty_i) begin
            s_ack_i = 1'b0;
            s_err_i = 1'b0;
            s_rty_i = 1'b0;
            sl_cnt  = 0;
         end else if (s_stb_o) begin
            sl_cnt++;
            if (sl_mode != 3 && sl_cnt > sl_lat) begin
               case (sl_mode)
                  0: begin
                     s_ack_i = 1'b1;
                     s_dat_i = sl_dat;
                  end
                  1: s_err_i = 1'b1;
                  default: s_rty_i = 1'b1;
               endcase
            end
         end else begin
            sl_cnt = 0;
         end
      end
   end

   // Monitor: grant rises and any master response pop the scoreboard.
   initial begin
      logic  pv;
      int    idle;
      gexp_t g;
      rexp_t e;
      pv   = 1'b0;
      idle = 1000;
      forever begin
         @(negedge clk);
         #2;
         if (gnt_vld_o && !pv) begin
            if (gq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL gnt_unexpected: got gnt %0d want none", gnt_o);
            end else begin
               g = gq.pop_front();
               chk("gnt_idx", 64'(gnt_o), 64'(g.gnt));
               if (g.idle >= 0) chk("gnt_idle", 64'(idle), 64'(g.idle));
            end
         end
         if (gnt_vld_o) idle = 0;
         else idle++;
         if ((m_ack_o | m_err_o | m_rty_o) != '0) begin
            if (rq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rsp_unexpected: got a=%b e=%b r=%b want none",
                        m_ack_o, m_err_o, m_rty_o);
            end else begin
               e = rq.pop_front();
               chk("rsp_ack", 64'(m_ack_o), 64'(e.ack));
               chk("rsp_err", 64'(m_err_o), 64'(e.err));
               chk("rsp_rty", 64'(m_rty_o), 64'(e.rty));
               chk("rsp_to", 64'(to_o), 64'(e.to));
               chk("rsp_stb", 64'(s_stb_o), 64'(e.stb));
               chk("rsp_gnt", 64'(gnt_o), 64'(e.gnt));
               if (e.cyc >= 0) chk("rsp_cyc", 64'(cyc_n), 64'(e.cyc));
               if (e.ck[0]) chk("rsp_dat", 64'(m_dat_o), 64'(e.dat));
               if (e.ck[1]) chk("rsp_adr", 64'(s_adr_o), 64'(e.adr));
            end
         end
         pv = gnt_vld_o;
      end
   end

   task automatic wait_resp(input int m);
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         #2;
         if (m_ack_o[m] | m_err_o[m] | m_rty_o[m]) break;
         t++;
         if (t > 300) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: master %0d got none want a response", m);
            break;
         end
      end
   endtask

   task automatic burst(input int m, input logic [31:0] a0, input int n,
                        input int gap);
      cyc[m] = 1'b1;
      we[m]  = 1'b1;
      sel[m] = '1;
      for (int i = 0; i < n; i++) begin
         adr[m]  = a0 + 32'(4 * i);
         wdat[m] = a0 + 32'(i);
         stb[m]  = 1'b1;
         wait_resp(m);
         @(posedge clk);
         #1;
         stb[m] = 1'b0;
         if (i < n - 1) begin
            repeat (gap) begin
               @(posedge clk);
               #1;
            end
         end
      end
      cyc[m] = 1'b0;
   endtask

   task automatic master_pair(input int m);
      repeat (2) begin
         burst(m, 32'h1000 + 32'(m * 16), 1, 0);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int n0;
      for (int k = 0; k < NM; k++) begin
         adr[k]  = '0;
         wdat[k] = '0;
         sel[k]  = '0;
         we[k]   = 1'b0;
         cyc[k]  = 1'b0;
         stb[k]  = 1'b0;
      end
      rst = 1'b1;
      step(2);

      // Reset state
      chk("rst_scyc", 64'(s_cyc_o), 64'd0);
      chk("rst_sstb", 64'(s_stb_o), 64'd0);
      chk("rst_vld", 64'(gnt_vld_o), 64'd0);
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_to", 64'(to_o), 64'd0);
      chk("rst_resp", 64'({m_ack_o, m_err_o, m_rty_o}), 64'd0);
      chk("rst_sadr", 64'(s_adr_o), 64'd0);
      chk("rst_sdat", 64'(s_dat_o), 64'd0);
      rst = 1'b0;
      step(1);

      // Single read by master 2
      sl_mode = 0;
      sl_lat  = 2;
      sl_dat  = 32'hDEAD_BEEF;
      pg(2, -1);
      pr(0, 2, -1, 3, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b1);
      adr[2] = 32'h10;
      sel[2] = 4'hF;
      we[2]  = 1'b0;
      cyc[2] = 1'b1;
      stb[2] = 1'b1;
      chk("lat_scyc0", 64'(s_cyc_o), 64'd0);
      step(1);
      chk("lat_scyc1", 64'(s_cyc_o), 64'd1);
      chk("rd_gnt", 64'(gnt_o), 64'd2);
      chk("rd_sadr", 64'(s_adr_o), 64'h10);
      chk("rd_swe", 64'(s_we_o), 64'd0);
      chk("rd_ssel", 64'(s_sel_o), 64'hF);
      wait_resp(2);
      step(1);
      stb[2] = 1'b0;
      cyc[2] = 1'b0;
      step(2);

      // Watchdog on master 3: silent slave
      sl_mode = 3;
      n0 = cyc_n;
      pg(3, -1);
      pr(1, 3, n0 + 9, 0, '0, '0, 1'b1, 1'b0);
      adr[3] = 32'h300;
      cyc[3] = 1'b1;
      stb[3] = 1'b1;
      wait_resp(3);
      repeat (3) begin
         step(1);
         chk("wd_hold_vld", 64'(gnt_vld_o), 64'd1);
         chk("wd_hold_gnt", 64'(gnt_o), 64'd3);
      end
      stb[3] = 1'b0;
      cyc[3] = 1'b0;
      step(2);

      // Fairness: all four masters, two rounds
      sl_mode = 0;
      sl_lat  = 0;
      for (int r = 0; r < 2; r++) begin
         for (int m = 0; m < NM; m++) begin
            pg(m, (r == 0 && m == 0) ? -1 : 1);
            pr(0, m, -1, 0, '0, '0, 1'b0, 1'b1);
         end
      end
      fork
         master_pair(0);
         master_pair(1);
         master_pair(2);
         master_pair(3);
      join
      step(3);

      // Burst hold: master 1 four words with gaps, master 0 waiting
      sl_lat = 1;
      pg(1, -1);
      pg(0, 1);
      for (int i = 0; i < 4; i++) begin
         pr(0, 1, -1, 2, '0, 32'h100 + 32'(4 * i), 1'b0, 1'b1);
      end
      pr(0, 0, -1, 2, '0, 32'h200, 1'b0, 1'b1);
      fork
         burst(1, 32'h100, 4, 3);
         begin
            step(2);
            burst(0, 32'h200, 1, 0);
         end
      join
      step(3);

      // Error to master 0, then retry to master 1
      sl_mode = 1;
      sl_lat  = 0;
      pg(0, -1);
      pr(1, 0, -1, 0, '0, '0, 1'b0, 1'b1);
      burst(0, 32'h400, 1, 0);
      step(1);
      sl_mode = 2;
      pg(1, 1);
      pr(2, 1, -1, 0, '0, '0, 1'b0, 1'b1);
      burst(1, 32'h500, 1, 0);
      step(3);

      // Reset while master 2 owns with STB high
      sl_mode = 3;
      pg(2, -1);
      adr[2] = 32'h600;
      cyc[2] = 1'b1;
      stb[2] = 1'b1;
      step(2);
      chk("mr_pre_vld", 64'(gnt_vld_o), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_scyc", 64'(s_cyc_o), 64'd0);
      chk("mr_sstb", 64'(s_stb_o), 64'd0);
      chk("mr_vld", 64'(gnt_vld_o), 64'd0);
      step(1);
      rst    = 1'b0;
      stb[2] = 1'b0;
      cyc[0] = 1'b1;
      pg(0, -1);
      step(1);
      chk("mr_post_gnt", 64'(gnt_o), 64'd0);
      chk("mr_post_vld", 64'(gnt_vld_o), 64'd1);
      cyc[0] = 1'b0;
      cyc[2] = 1'b0;
      step(5);

      chk("gq_empty", 64'(gq.size()), 64'd0);
      chk("rq_empty", 64'(rq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
